// File: rtl/ysyx_22051013_mem_arbiter_pkg.sv
// Shared types for the IFU/LSU data-memory arbiter: FSM states, owner IDs, watchdog default.
// Optional round-robin arbitration is enabled by defining MEM_ARB_RR_EN.
package ysyx_22051013_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  localparam int TIMEOUT_CYC_DEF = 255;

  // Reads always fetch the whole naturally aligned doubleword.
  function automatic logic [63:0] alignDword(input logic [63:0] addr);
    return {addr[63:3], 3'b000};
  endfunction

endpackage

// File: rtl/ysyx_22051013_mem_arb_pick.sv
// Combinational grant between IFU and LSU requests.
// MEM_ARB_RR_EN selects round-robin on ties; otherwise LSU has fixed priority.
module ysyx_22051013_mem_arb_pick
  import ysyx_22051013_mem_arbiter_pkg::*;
(
  input  logic   if_valid_i,
  input  logic   ls_valid_i,
`ifdef MEM_ARB_RR_EN
  input  owner_e last_grant_i,
`endif
  output logic   grant_valid_o,
  output owner_e grant_o
);

  always_comb begin
    grant_valid_o = if_valid_i | ls_valid_i;
    grant_o       = OWN_LS;
    if (if_valid_i && !ls_valid_i) begin
      grant_o = OWN_IF;
    end
`ifdef MEM_ARB_RR_EN
    // On a tie, hand the port to whoever did not get it last time.
    else if (if_valid_i && ls_valid_i && last_grant_i == OWN_LS) begin
      grant_o = OWN_IF;
    end
`endif
  end

endmodule

// File: rtl/ysyx_22051013_mem_arbiter.sv
// Shares one 64-bit data-memory port between IFU and LSU: one transaction at a time with watchdog.
// Define MEM_ARB_RR_EN for round-robin tie-breaking instead of fixed LSU priority.
module ysyx_22051013_mem_arbiter
  import ysyx_22051013_mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_valid,
  input  logic [63:0] if_addr,
  output logic        if_req_ready,
  output logic        if_resp_valid,
  output logic [63:0] if_rdata,
  input  logic        ls_req_valid,
  input  logic        ls_we,
  input  logic [63:0] ls_addr,
  input  logic [63:0] ls_wdata,
  input  logic [7:0]  ls_wmask,
  output logic        ls_req_ready,
  output logic        ls_resp_valid,
  output logic [63:0] ls_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_rdata,
  output logic        busy,
  output logic        err_timeout
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC);

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic          we_q, we_d;
  logic [63:0]   addr_q, addr_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [7:0]    wmask_q, wmask_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic          grantValid;
  owner_e        grant;
  logic          accept;
  logic          respFire;
  logic [63:0]   respData;
  logic [63:0]   reqAddr;
  logic          reqWe;

`ifdef MEM_ARB_RR_EN
  owner_e        last_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= OWN_IF;
    end else if (accept) begin
      last_q <= grant;
    end
  end
`endif

  ysyx_22051013_mem_arb_pick u_pick (
    .if_valid_i    (if_req_valid),
    .ls_valid_i    (ls_req_valid),
`ifdef MEM_ARB_RR_EN
    .last_grant_i  (last_q),
`endif
    .grant_valid_o (grantValid),
    .grant_o       (grant)
  );

  assign reqWe   = (grant == OWN_LS) && ls_we;
  assign reqAddr = (grant == OWN_LS) ? ls_addr : if_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= OWN_LS;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    accept   = 1'b0;
    respFire = 1'b0;
    respData = '0;
    unique case (state_q)
      IDLE: begin
        if (grantValid) begin
          accept  = 1'b1;
          owner_d = grant;
          we_d    = reqWe;
          addr_d  = reqWe ? reqAddr : alignDword(reqAddr);
          wdata_d = (grant == OWN_LS) ? ls_wdata : '0;
          wmask_d = reqWe ? ls_wmask : '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A real response in the same cycle as the deadline takes precedence.
        if (mem_resp_valid) begin
          respFire = 1'b1;
          respData = we_q ? '0 : mem_rdata;
          state_d  = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          respFire = 1'b1;
          err_d    = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign if_req_ready  = rst && accept && (grant == OWN_IF);
  assign ls_req_ready  = rst && accept && (grant == OWN_LS);
  assign if_resp_valid = respFire && (owner_q == OWN_IF);
  assign ls_resp_valid = respFire && (owner_q == OWN_LS);
  assign if_rdata      = (owner_q == OWN_IF) ? respData : '0;
  assign ls_rdata      = (owner_q == OWN_LS) ? respData : '0;
  assign mem_req_valid = (state_q == REQ);
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign busy          = (state_q != IDLE);
  assign err_timeout   = err_q;

endmodule

// File: tb/tb_ysyx_22051013_mem_arbiter.sv
// Self-checking bench for the memory arbiter with a response scoreboard; watchdog set to 8 cycles.
// Expected tie-breaking follows MEM_ARB_RR_EN when it is defined.
module tb_ysyx_22051013_mem_arbiter;

  typedef struct {
    logic        isLs;
    logic [63:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready, if_resp_valid;
  logic [63:0] if_addr, if_rdata;
  logic        ls_req_valid, ls_we, ls_req_ready, ls_resp_valid;
  logic [63:0] ls_addr, ls_wdata, ls_rdata;
  logic [7:0]  ls_wmask;
  logic        mem_req_valid, mem_req_ready, mem_we, mem_resp_valid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;
  logic        busy, err_timeout;

  int   checks = 0;
  int   passed = 0;
  exp_t sbQ[$];
`ifdef MEM_ARB_RR_EN
  logic lastLs = 1'b0;
`endif

  ysyx_22051013_mem_arbiter #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_addr(if_addr), .if_req_ready(if_req_ready),
    .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
    .ls_req_valid(ls_req_valid), .ls_we(ls_we), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_wmask(ls_wmask), .ls_req_ready(ls_req_ready),
    .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && (if_resp_valid || ls_resp_valid)) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_resp", {62'd0, if_resp_valid, ls_resp_valid}, 64'd0);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        checkOutput("resp_owner_ls", {63'd0, ls_resp_valid}, {63'd0, e.isLs});
        checkOutput("resp_owner_if", {63'd0, if_resp_valid}, {63'd0, !e.isLs});
        checkOutput("resp_data", e.isLs ? ls_rdata : if_rdata, e.data);
      end
    end
  end

  task automatic applyStimulus(input logic ifV, input logic lsV, input logic lsWe,
                               input logic [63:0] ifA, input logic [63:0] lsA,
                               input logic [63:0] wd, input logic [7:0] wm,
                               input int stall, input int delay, input logic [63:0] rd);
    logic        winLs, expWe;
    logic [63:0] reqA, expA;
    logic [7:0]  expM;
    exp_t        e;
    if (ifV && lsV) begin
`ifdef MEM_ARB_RR_EN
      winLs = !lastLs;
`else
      winLs = 1'b1;
`endif
    end else begin
      winLs = lsV;
    end
`ifdef MEM_ARB_RR_EN
    lastLs = winLs;
`endif
    expWe = winLs && lsWe;
    reqA  = winLs ? lsA : ifA;
    expA  = expWe ? reqA : {reqA[63:3], 3'b000};
    expM  = expWe ? wm : 8'h00;
    if_req_valid = ifV;  ls_req_valid = lsV;  ls_we = lsWe;
    if_addr = ifA;  ls_addr = lsA;  ls_wdata = wd;  ls_wmask = wm;
    #1;
    checkOutput("if_req_ready", {63'd0, if_req_ready}, {63'd0, !winLs});
    checkOutput("ls_req_ready", {63'd0, ls_req_ready}, {63'd0, winLs});
    e.isLs = winLs;
    e.data = expWe ? 64'd0 : rd;
    sbQ.push_back(e);
    tick();
    if_req_valid = 1'b0;  ls_req_valid = 1'b0;
    #1;
    checkOutput("mem_req_valid", {63'd0, mem_req_valid}, 64'd1);
    checkOutput("mem_addr", mem_addr, expA);
    checkOutput("mem_we", {63'd0, mem_we}, {63'd0, expWe});
    checkOutput("mem_wmask", {56'd0, mem_wmask}, {56'd0, expM});
    if (expWe) checkOutput("mem_wdata", mem_wdata, wd);
    for (int i = 0; i < stall; i++) begin
      if_req_valid = 1'b1;  ls_req_valid = 1'b1;
      #1;
      checkOutput("stall_if_ready", {63'd0, if_req_ready}, 64'd0);
      checkOutput("stall_ls_ready", {63'd0, ls_req_ready}, 64'd0);
      checkOutput("stall_valid", {63'd0, mem_req_valid}, 64'd1);
      checkOutput("stall_addr", mem_addr, expA);
      checkOutput("stall_busy", {63'd0, busy}, 64'd1);
      tick();
    end
    if_req_valid = 1'b0;  ls_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    repeat (delay) tick();
    mem_resp_valid = 1'b1;  mem_rdata = rd;
    tick();
    mem_resp_valid = 1'b0;  mem_rdata = 64'd0;
    #1;
    checkOutput("idle_after_resp", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    rst = 1'b0;
    if_req_valid = 1'b1;  if_addr = 64'h8000_0000;
    ls_req_valid = 1'b1;  ls_we = 1'b0;  ls_addr = 64'd0;  ls_wdata = 64'd0;  ls_wmask = 8'd0;
    mem_req_ready = 1'b0;  mem_resp_valid = 1'b0;  mem_rdata = 64'd0;
    repeat (2) tick();
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_mem_valid", {63'd0, mem_req_valid}, 64'd0);
    checkOutput("rst_mem_addr", mem_addr, 64'd0);
    checkOutput("rst_err", {63'd0, err_timeout}, 64'd0);
    checkOutput("rst_if_ready", {63'd0, if_req_ready}, 64'd0);
    checkOutput("rst_ls_ready", {63'd0, ls_req_ready}, 64'd0);
    if_req_valid = 1'b0;  ls_req_valid = 1'b0;
    rst = 1'b1;
    tick();

    // Stray response while idle must be ignored.
    mem_resp_valid = 1'b1;  mem_rdata = 64'h1234;
    tick();
    mem_resp_valid = 1'b0;  mem_rdata = 64'd0;
    checkOutput("stray_busy", {63'd0, busy}, 64'd0);

    applyStimulus(1'b1, 1'b0, 1'b0, 64'h8000_0004, 64'd0, 64'd0, 8'h00, 0, 0, 64'hDEAD);
    applyStimulus(1'b0, 1'b1, 1'b1, 64'd0, 64'h8000_0013, 64'h11, 8'h08, 0, 0, 64'hFFFF);
    applyStimulus(1'b0, 1'b1, 1'b0, 64'd0, 64'h8000_0027, 64'd0, 8'hFF, 5, 2, 64'hCAFE_F00D_1234_5678);
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h8000_1000, 64'h8000_2008, 64'd0, 8'h00, 0, 1, 64'hA1);
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h8000_100C, 64'h8000_2010, 64'd0, 8'h00, 0, 0, 64'hB2);
    // Response lands exactly on the watchdog deadline: no error.
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h8000_3005, 64'd0, 64'd0, 8'h00, 0, 8, 64'h77);
    checkOutput("resp_at_deadline_err", {63'd0, err_timeout}, 64'd0);

    // Watchdog abort on an LSU load with no response.
    ls_req_valid = 1'b1;  ls_we = 1'b0;  ls_addr = 64'h8000_0100;
    #1;
    checkOutput("wd_ls_ready", {63'd0, ls_req_ready}, 64'd1);
    begin
      exp_t e;
      e.isLs = 1'b1;  e.data = 64'd0;
      sbQ.push_back(e);
    end
`ifdef MEM_ARB_RR_EN
    lastLs = 1'b1;
`endif
    tick();
    ls_req_valid = 1'b0;  mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;  mem_rdata = 64'hBAD;
    for (int k = 0; k < 8; k++) begin
      checkOutput("wd_quiet", {63'd0, ls_resp_valid}, 64'd0);
      tick();
    end
    checkOutput("wd_pulse", {63'd0, ls_resp_valid}, 64'd1);
    checkOutput("wd_rdata", ls_rdata, 64'd0);
    checkOutput("wd_err_pre", {63'd0, err_timeout}, 64'd0);
    tick();
    mem_rdata = 64'd0;
    checkOutput("wd_err_set", {63'd0, err_timeout}, 64'd1);
    checkOutput("wd_idle", {63'd0, busy}, 64'd0);

    applyStimulus(1'b0, 1'b1, 1'b0, 64'd0, 64'h8000_0200, 64'd0, 8'h00, 0, 3, 64'h5555);
    checkOutput("err_sticky", {63'd0, err_timeout}, 64'd1);

    // Reset while a transaction is in flight drops it.
    if_req_valid = 1'b1;  if_addr = 64'h8000_0040;
    tick();
    if_req_valid = 1'b0;  mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    checkOutput("inflight_busy", {63'd0, busy}, 64'd1);
    rst = 1'b0;
    #1;
    checkOutput("arst_busy", {63'd0, busy}, 64'd0);
    checkOutput("arst_mem_valid", {63'd0, mem_req_valid}, 64'd0);
    checkOutput("arst_mem_addr", mem_addr, 64'd0);
    checkOutput("arst_err", {63'd0, err_timeout}, 64'd0);
    mem_resp_valid = 1'b1;  mem_rdata = 64'h99;
    tick();
    rst = 1'b1;
`ifdef MEM_ARB_RR_EN
    lastLs = 1'b0;
`endif
    tick();
    checkOutput("late_resp_ignored", {62'd0, if_resp_valid, ls_resp_valid}, 64'd0);
    mem_resp_valid = 1'b0;  mem_rdata = 64'd0;
    tick();

    applyStimulus(1'b1, 1'b1, 1'b0, 64'h8000_4000, 64'h8000_5001, 64'd0, 8'h00, 0, 0, 64'hC3);

    repeat (2) tick();
    checkOutput("sb_drained", 64'(sbQ.size()), 64'd0);
    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
